// File: rtl/bilerp_pkg.sv
// bilerp_pkg: shared widths, rounding constant and FSM encoding for bilerp_seq
package bilerp_pkg;
    localparam int DEF_PW     = 8;
    localparam int DEF_FW     = 8;
    localparam int PROD_W     = DEF_PW + DEF_FW + 2;
    localparam int ROUND_HALF = 1 << (DEF_FW - 1);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TOP  = 3'd1;
    localparam logic [2:0] S_BOT  = 3'd2;
    localparam logic [2:0] S_VERT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/bilerp_seq_if.sv
// bilerp_seq_if: upstream neighbour/fraction stream and downstream pixel stream
interface bilerp_seq_if
    import bilerp_pkg::*;
#(
    parameter int PW = DEF_PW,
    parameter int FW = DEF_FW
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] p00;
    logic [PW-1:0] p01;
    logic [PW-1:0] p10;
    logic [PW-1:0] p11;
    logic [FW-1:0] fx;
    logic [FW-1:0] fy;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pix;
    logic          busy;

    modport master (
        output in_valid, p00, p01, p10, p11, fx, fy, out_ready,
        input  in_ready, out_valid, out_pix, busy
    );

    modport slave (
        input  in_valid, p00, p01, p10, p11, fx, fy, out_ready,
        output in_ready, out_valid, out_pix, busy
    );
endinterface

// File: rtl/bilerp_seq_lerp_unit.sv
// lerp_unit: combinational a + round((b - a) * f / 2^FW), saturated to the pixel range
module lerp_unit
    import bilerp_pkg::*;
#(
    parameter int PW = DEF_PW,
    parameter int FW = DEF_FW
) (
    input  logic [PW-1:0] a,
    input  logic [PW-1:0] b,
    input  logic [FW-1:0] f,
    output logic [PW-1:0] y
);
    localparam int PRW = PW + FW + 2;
    localparam logic signed [PRW-1:0] RH = PRW'(1) <<< (FW - 1);

    logic signed [PW:0]    d;
    logic signed [PRW-1:0] prod;
    logic signed [PRW-1:0] r;
    logic signed [PRW:0]   s;

    // signed difference, weighted, rounded half-up by arithmetic shift, then clamped
    always_comb begin
        d    = $signed({1'b0, b}) - $signed({1'b0, a});
        prod = PRW'(d) * PRW'($signed({1'b0, f}));
        r    = (prod + RH) >>> FW;
        s    = $signed({{(PRW + 1 - PW){1'b0}}, a}) + (PRW + 1)'(r);
        y    = s[PRW] ? '0 : (|s[PRW-1:PW]) ? '1 : s[PW-1:0];
    end
endmodule

// File: rtl/bilerp_seq.sv
// bilerp_seq: bilinear pixel from three sequential lerps on one shared lerp_unit
module bilerp_seq
    import bilerp_pkg::*;
#(
    parameter int PW = DEF_PW,
    parameter int FW = DEF_FW
) (
    input logic         clk,
    input logic         rst,
    bilerp_seq_if.slave bus
);
    logic [2:0]    state;
    logic [2:0]    state_n;
    logic [PW-1:0] c00, c01, c10, c11;
    logic [FW-1:0] cfx, cfy;
    logic [PW-1:0] top_r, bot_r, pix_r;
    logic [PW-1:0] la, lb, ly;
    logic [FW-1:0] lf;
    logic          accept;

    assign bus.in_ready  = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
    assign bus.out_valid = state == S_DONE;
    assign bus.busy      = state != S_IDLE;
    assign bus.out_pix   = pix_r;
    assign accept        = bus.in_valid && bus.in_ready;

    // operand mux: the state picks which of the three lerps runs this cycle
    always_comb begin
        la = state == S_TOP ? c00 : state == S_BOT ? c10 : top_r;
        lb = state == S_TOP ? c01 : state == S_BOT ? c11 : bot_r;
        lf = state == S_VERT ? cfy : cfx;
    end

    lerp_unit #(.PW(PW), .FW(FW)) u_lerp (.a(la), .b(lb), .f(lf), .y(ly));

    // next state; an accept in DONE goes straight to TOP so streaming has no bubble
    always_comb begin
        state_n = accept ? S_TOP :
                  state == S_TOP  ? S_BOT :
                  state == S_BOT  ? S_VERT :
                  state == S_VERT ? S_DONE :
                  (state == S_DONE && bus.out_ready) ? S_IDLE : state;
    end

    // state, input capture on accept, and the three result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            {c00, c01, c10, c11, cfx, cfy} <= '0;
            top_r <= '0;
            bot_r <= '0;
            pix_r <= '0;
        end else begin
            state <= state_n;
            if (accept) {c00, c01, c10, c11, cfx, cfy} <= {bus.p00, bus.p01, bus.p10, bus.p11, bus.fx, bus.fy};
            if (state == S_TOP) top_r <= ly;
            if (state == S_BOT) bot_r <= ly;
            if (state == S_VERT) pix_r <= ly;
        end
    end
endmodule

// File: tb/tb_bilerp_seq.sv
// tb_bilerp_seq: directed and randomized checks of bilerp_seq against a bilinear reference model
module tb_bilerp_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;

    bilerp_seq_if #(.PW(8), .FW(8)) bus ();

    bilerp_seq #(.PW(8), .FW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // free-running edge counter used to measure accept spacing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_lerp(input int a, input int b, input int f);
        int r;
        int s;
        r = ((b - a) * f + 128) >>> 8;
        s = a + r;
        return s < 0 ? 0 : s > 255 ? 255 : s;
    endfunction

    function automatic int ref_bilerp(input int a, input int b, input int c, input int d, input int x, input int y);
        return ref_lerp(ref_lerp(a, b, x), ref_lerp(c, d, x), y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int a, input int b, input int c, input int d, input int x, input int y);
        bus.p00 = 8'(a);
        bus.p01 = 8'(b);
        bus.p10 = 8'(c);
        bus.p11 = 8'(d);
        bus.fx  = 8'(x);
        bus.fy  = 8'(y);
    endtask

    task automatic scramble();
        set_in($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check({tag, "_accept_timeout"}, 0, 1);
        tick();
        bus.in_valid = 1'b0;
        scramble();
    endtask

    task automatic do_txn(input string tag, input int a, input int b, input int c, input int d,
                          input int x, input int y, input int exp, input int stall);
        int lat;
        set_in(a, b, c, d, x, y);
        bus.out_ready = 1'b1;
        wait_accept(tag);
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_pix"}, int'(bus.out_pix), exp);
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            repeat (stall) tick();
            check({tag, "_stall_pix"}, int'(bus.out_pix), exp);
            bus.out_ready = 1'b1;
        end
        tick();
        check({tag, "_released"}, int'(bus.out_valid), 0);
    endtask

    int sp[5][6];
    int q[$];
    int acc;
    int last_acc;
    int outs;
    int gaps;
    int idx;
    int seen;

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        scramble();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_pix", int'(bus.out_pix), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_top_r", int'(dut.top_r), 0);
        check("rst_bot_r", int'(dut.bot_r), 0);

        set_in(0, 100, 100, 200, 128, 128);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        scramble();
        tick();
        check("mid_top_r", int'(dut.top_r), 50);
        check("mid_early_valid", int'(bus.out_valid), 0);
        tick();
        check("mid_bot_r", int'(dut.bot_r), 150);
        check("mid_early_valid2", int'(bus.out_valid), 0);
        tick();
        check("mid_valid", int'(bus.out_valid), 1);
        check("mid_pix", int'(bus.out_pix), 100);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_pix", int'(bus.out_pix), 100);
            check("hold_in_ready", int'(bus.in_ready), 0);
            check("hold_busy", int'(bus.busy), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("mid_released", int'(bus.out_valid), 0);

        do_txn("zero_w", 37, 200, 200, 200, 0, 0, 37, 0);
        do_txn("neg_slope", 20, 10, 0, 0, 128, 0, 15, 1);
        check("neg_slope_top_r", int'(dut.top_r), 15);
        do_txn("ext_ramp", 0, 255, 0, 0, 255, 0, 254, 0);
        do_txn("ext_max", 255, 255, 255, 255, 255, 255, 255, 2);

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) sp[i][j] = $urandom_range(0, 255);
            sp[i][4] = $urandom_range(0, 255);
            sp[i][5] = $urandom_range(0, 255);
        end
        idx = 0;
        outs = 0;
        gaps = 0;
        last_acc = -1;
        bus.out_ready = 1'b1;
        set_in(sp[0][0], sp[0][1], sp[0][2], sp[0][3], sp[0][4], sp[0][5]);
        bus.in_valid = 1'b1;
        for (int n = 0; n < 60 && outs < 5; n++) begin
            acc = int'(bus.in_valid && bus.in_ready);
            if (bus.out_valid) begin
                if (q.size() == 0) check("stream_unexpected_out", 1, 0);
                else check("stream_pix", int'(bus.out_pix), q.pop_front());
                outs++;
            end
            if (idx > 0 && !bus.busy) gaps++;
            tick();
            if (acc != 0) begin
                if (last_acc >= 0) check("stream_accept_gap", cyc - last_acc, 4);
                last_acc = cyc;
                q.push_back(ref_bilerp(sp[idx][0], sp[idx][1], sp[idx][2], sp[idx][3], sp[idx][4], sp[idx][5]));
                idx++;
                if (idx < 5) set_in(sp[idx][0], sp[idx][1], sp[idx][2], sp[idx][3], sp[idx][4], sp[idx][5]);
                else begin
                    bus.in_valid = 1'b0;
                    scramble();
                end
            end
        end
        check("stream_outputs", outs, 5);
        check("stream_bubbles", gaps, 0);
        tick();
        check("stream_idle", int'(bus.busy), 0);

        set_in(10, 250, 90, 30, 77, 200);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_in_ready", int'(bus.in_ready), 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("abort_no_output", seen, 0);
        do_txn("after_abort", 60, 61, 62, 63, 64, 65, ref_bilerp(60, 61, 62, 63, 64, 65), 0);

        for (int i = 0; i < 20; i++) begin
            int a, b, c, d, x, y;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            c = $urandom_range(0, 255);
            d = $urandom_range(0, 255);
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            do_txn("rand", a, b, c, d, x, y, ref_bilerp(a, b, c, d, x, y), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
